// File: rtl/lt_spi_master.sv
// SPI master (mode 0, MSB first) issuing fixed 40-bit register-access frames
// to the lt_avalon_out slave, plus a synchroniser for the slave's sint line.
module lt_spi_master #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [6:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  input  logic        spi_sint,
  output logic        sint_level,
  output logic        sint_rise
);

  localparam int unsigned HW = $clog2(CLK_DIV) + 1;
  localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] G_LAST = GW'(CS_GAP - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  logic [2:0]    state;
  logic [39:0]   sreg;
  logic [31:0]   rx;
  logic [HW-1:0] hcnt;
  logic [5:0]    bcnt;
  logic [GW-1:0] gcnt;
  logic          sint_ff1;
  logic          sint_prev;

  assign cmd_ready = (state == ST_IDLE) & ~rst;
  // MOSI comes straight from the shift register MSB; the register is zero outside a frame.
  assign spi_mosi  = sreg[39];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      spi_cs    <= 1'b1;
      spi_sclk  <= 1'b0;
      sreg      <= '0;
      rx        <= '0;
      hcnt      <= '0;
      bcnt      <= '0;
      gcnt      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            sreg   <= {cmd_write, cmd_addr, cmd_write ? cmd_wdata : 32'h0};
            spi_cs <= 1'b0;
            hcnt   <= '0;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (hcnt == H_LAST) begin
            hcnt     <= '0;
            bcnt     <= '0;
            spi_sclk <= 1'b1;
            state    <= ST_SHIFT;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (hcnt != H_LAST) begin
            hcnt <= hcnt + 1'b1;
          end else begin
            hcnt <= '0;
            if (spi_sclk) begin
              // End of high phase: sample MISO; only the last 32 samples survive in rx.
              spi_sclk <= 1'b0;
              rx       <= {rx[30:0], spi_miso};
              if (bcnt != 6'd39)
                sreg <= {sreg[38:0], 1'b0};
            end else if (bcnt == 6'd39) begin
              state <= ST_HOLD;
            end else begin
              bcnt     <= bcnt + 1'b1;
              spi_sclk <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (hcnt == H_LAST) begin
            hcnt      <= '0;
            spi_cs    <= 1'b1;
            sreg      <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= rx;
            gcnt      <= '0;
            state     <= ST_GAP;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gcnt == G_LAST)
            state <= ST_IDLE;
          else
            gcnt <= gcnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sint_ff1   <= 1'b0;
      sint_level <= 1'b0;
      sint_prev  <= 1'b0;
      sint_rise  <= 1'b0;
    end else begin
      sint_ff1   <= spi_sint;
      sint_level <= sint_ff1;
      sint_prev  <= sint_level;
      sint_rise  <= sint_level & ~sint_prev;
    end
  end

endmodule

// File: tb/tb_lt_spi_master.sv
// Directed bench for lt_spi_master with a mode-0 slave model on MISO.
module tb_lt_spi_master;

  localparam int unsigned DIV = 2;
  localparam int unsigned GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [6:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        spi_cs, spi_sclk, spi_mosi;
  logic        spi_miso = 1'b0;
  logic        spi_sint = 1'b0;
  logic        sint_level, sint_rise;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [39:0] mosi_cap;
  int unsigned rise_cnt;
  logic [39:0] slave_word = '0;
  logic [39:0] slave_sh;
  int unsigned sr_cnt = 0;

  lt_spi_master #(.CLK_DIV(DIV), .CS_GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_sint(spi_sint), .sint_level(sint_level), .sint_rise(sint_rise)
  );

  always #5 clk = ~clk;

  always @(posedge spi_sclk) begin
    mosi_cap = {mosi_cap[38:0], spi_mosi};
    rise_cnt = rise_cnt + 1;
  end

  always @(negedge spi_cs) begin
    slave_sh = slave_word;
    spi_miso = slave_sh[39];
  end

  always @(negedge spi_sclk) begin
    slave_sh = {slave_sh[38:0], 1'b0};
    spi_miso = slave_sh[39];
  end

  always @(negedge clk) if (sint_rise) sr_cnt = sr_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int unsigned n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check({tag, "_ready_timeout"}, 0, 1);
  endtask

  // Presents a command and returns just after the accepting edge.
  task automatic do_cmd(input logic wr, input logic [6:0] a, input logic [31:0] d, input logic keep);
    @(negedge clk);
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  // Follows one frame from cycle 1 after accept up to rsp_valid.
  task automatic run_frame(input string tag, input logic [39:0] exp_mosi,
                           input logic chk_rd, input logic [31:0] exp_rd,
                           input int unsigned pulse_at);
    int unsigned k = 0, cs_low = 0, rdy = 0, rv_k = 0;
    mosi_cap = '0;
    rise_cnt = 0;
    while (rv_k == 0 && k < 400) begin
      @(negedge clk);
      k++;
      if (pulse_at != 0 && k == pulse_at) cmd_valid = 1'b1;
      if (pulse_at != 0 && k == pulse_at + 1) cmd_valid = 1'b0;
      if (!spi_cs) cs_low++;
      if (cmd_ready) rdy++;
      if (rsp_valid) rv_k = k;
    end
    check({tag, "_rsp_cycle"}, 64'(rv_k), 64'(82 * DIV + 1));
    check({tag, "_cs_low"}, 64'(cs_low), 64'(82 * DIV));
    check({tag, "_ready_in_frame"}, 64'(rdy), 0);
    check({tag, "_sclk_rises"}, 64'(rise_cnt), 40);
    check({tag, "_mosi"}, 64'(mosi_cap), 64'(exp_mosi));
    if (chk_rd) check({tag, "_rdata"}, 64'(rsp_rdata), 64'(exp_rd));
  endtask

  initial begin
    int unsigned n;
    int unsigned seen;

    #12;
    check("rst_ready", 64'(cmd_ready), 0);
    check("rst_cs", 64'(spi_cs), 1);
    check("rst_sclk", 64'(spi_sclk), 0);
    check("rst_mosi", 64'(spi_mosi), 0);
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_rdata", 64'(rsp_rdata), 0);
    check("rst_sint", 64'({sint_level, sint_rise}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", 64'(cmd_ready), 1);

    // Write frame
    slave_word = 40'h00_CAFEF00D;
    do_cmd(1'b1, 7'h05, 32'hDEADBEEF, 1'b0);
    run_frame("wr", 40'h85_DEADBEEF, 1'b1, 32'hCAFEF00D, 0);
    wait_ready("wr");

    // Read frame; first 8 slave bits fall outside the data phase
    slave_word = 40'hA5_12345678;
    do_cmd(1'b0, 7'h7F, 32'hFFFFFFFF, 1'b0);
    run_frame("rd", 40'h7F_00000000, 1'b1, 32'h12345678, 0);
    wait_ready("rd");

    // Back-to-back with cmd_valid held high
    slave_word = 40'h00_0BADCAFE;
    do_cmd(1'b1, 7'h22, 32'h01234567, 1'b1);
    run_frame("b2b1", 40'hA2_01234567, 1'b1, 32'h0BADCAFE, 0);
    cmd_write = 1'b0;
    cmd_addr  = 7'h33;
    cmd_wdata = 32'h89ABCDEF;
    slave_word = 40'h00_55AA33CC;
    n = 1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      if (!cmd_ready) begin
        n++;
        if (!spi_cs) check("b2b_cs_gap_low", 1, 0);
      end
    end
    check("b2b_gap", 64'(n), 64'(GAP));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    run_frame("b2b2", 40'h33_00000000, 1'b1, 32'h55AA33CC, 0);
    wait_ready("b2b2");

    // Inputs change after accept and a stray mid-frame cmd_valid pulse
    slave_word = '0;
    do_cmd(1'b1, 7'h4C, 32'h13579BDF, 1'b0);
    cmd_addr  = 7'h01;
    cmd_wdata = 32'hFFFF0000;
    cmd_write = 1'b0;
    run_frame("latch", 40'hCC_13579BDF, 1'b0, 32'h0, 50);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!spi_cs) seen++;
    end
    check("latch_no_second_frame", 64'(seen), 0);

    // Reset in the middle of a frame
    slave_word = '0;
    do_cmd(1'b1, 7'h10, 32'hFFFFFFFF, 1'b0);
    rise_cnt = 0;
    n = 0;
    while (rise_cnt < 20 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached_bit20", 64'(rise_cnt), 20);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_cs", 64'(spi_cs), 1);
    check("midrst_sclk", 64'(spi_sclk), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid || !spi_cs) seen++;
    end
    check("midrst_no_rsp", 64'(seen), 0);
    check("midrst_ready", 64'(cmd_ready), 1);
    do_cmd(1'b1, 7'h11, 32'h00000001, 1'b0);
    run_frame("postrst", 40'h91_00000001, 1'b1, 32'h0, 0);
    wait_ready("postrst");

    // sint synchroniser
    @(negedge clk);
    sr_cnt = 0;
    #2;
    spi_sint = 1'b1;
    n = 0;
    while (!sint_level && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("sint_latency_le3", 64'(n >= 2 && n <= 3), 1);
    repeat (6) @(negedge clk);
    check("sint_rise_once", 64'(sr_cnt), 1);
    sr_cnt = 0;
    #3;
    spi_sint = 1'b0;
    repeat (8) @(negedge clk);
    check("sint_fall_level", 64'(sint_level), 0);
    check("sint_no_fall_pulse", 64'(sr_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lt_spi_master.md
# lt_spi_master

SPI master that drives the board-to-board serial link whose slave end is the `lt_avalon_out` SPI port (cs/sdi/sdo/sclk/sint) of the LT24 SOPC system. It sits in the peer FPGA, or in a test harness, opposite that slave. It converts single register-access commands into fixed 40-bit SPI frames (mode 0, MSB first) and returns the read data. It also synchronises the slave's `sint` interrupt line.

## Interface
- `CLK_DIV`, default 4: half-period of `spi_sclk`, in `clk` cycles; legal values ≥2.
- `CS_GAP`, default 4: minimum number of `clk` cycles `spi_cs` stays high between frames; legal values ≥1.
- `clk` in 1: single system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE; a command is accepted on a cycle where `cmd_valid & cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 7: register address.
- `cmd_wdata` in 32: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle pulse at frame end.
- `rsp_rdata` out 32: data captured from MISO during the data phase; held until the next `rsp_valid`.
- `spi_cs` out 1: chip select, active-low.
- `spi_sclk` out 1: serial clock, idle low.
- `spi_mosi` out 1: master-out data.
- `spi_miso` in 1: slave-out data.
- `spi_sint` in 1: asynchronous interrupt from the slave.
- `sint_level` out 1: `spi_sint` after a 2-flop synchroniser.
- `sint_rise` out 1: one-cycle pulse on a rising edge of `sint_level`.

## Operation
- Frame layout, 40 bits, MSB first:
  - bit 39 = `cmd_write`
  - bits 38:32 = `cmd_addr`
  - bits 31:0 = `cmd_wdata` for writes, all zero for reads.
- All command fields are latched into a 40-bit shift register at accept. Later changes on the inputs have no effect on the frame in progress.
- FSM states: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
  - IDLE: `cs`=1, `sclk`=0, `mosi`=0, `cmd_ready`=1.
  - SETUP: `cs`=0, `sclk`=0, `mosi`=bit 39. Lasts CLK_DIV cycles.
  - SHIFT: 40 bit periods. Each period is `sclk` high for CLK_DIV cycles, then low for CLK_DIV cycles. At every high→low transition except after the last bit, `mosi` advances to the next bit. Lasts 80·CLK_DIV cycles.
  - HOLD: `cs`=0, `sclk`=0 for CLK_DIV cycles.
  - GAP: `cs`=1 for CS_GAP cycles; `cmd_ready`=0.
- MISO sampling: `spi_miso` is sampled on the `clk` edge that drives `sclk` high→low, i.e. at the end of each high phase. The bits sampled in bit periods 31..0 are shifted into `rsp_rdata[31:0]`, MSB first. MISO is sampled for both reads and writes.
- `rsp_valid` pulses, and `rsp_rdata` updates, on the edge that enters GAP.
- A 6-bit bit counter and a half-period counter of width ⌈log2(CLK_DIV)⌉+1 control the SHIFT state. Both wrap only through the FSM and are never free-running.
- `cmd_valid` asserted outside IDLE is ignored. There is no queueing.

## Timing
- Accept happens in cycle 0. `spi_cs` falls at the start of cycle 1.
- `spi_cs` stays low for exactly 82·CLK_DIV cycles.
- `rsp_valid` is high in cycle 82·CLK_DIV+1.
- The earliest next accept is in cycle 82·CLK_DIV+1+CS_GAP.
- Every frame has exactly 40 `sclk` rising edges.
- `sint_level` lags `spi_sint` by 2–3 cycles. `sint_rise` is high in the cycle after `sint_level` rises.
- Reset values while `rst`=1:
  - `cmd_ready`=1 on release, 0 while in reset.
  - `rsp_valid`=0, `rsp_rdata`=0.
  - `spi_cs`=1, `spi_sclk`=0, `spi_mosi`=0.
  - `sint_level`=0, `sint_rise`=0.
  - FSM in IDLE.
- Reset mid-frame: `cs` goes high and `sclk` goes low asynchronously. No `rsp_valid` is produced for the aborted frame. The next accepted command runs a complete frame.
- Simultaneous `rsp_valid` and `sint_rise` are independent of each other; neither masks the other.

## Test plan
- Write, CLK_DIV=2, addr 0x05, wdata 0xDEADBEEF → MOSI, sampled at `sclk` rises, equals 0x85DEADBEEF; `cs` low for 164 cycles; `rsp_valid` in cycle 165; 40 `sclk` rises counted.
- Read, addr 0x7F, slave model drives 0x12345678 (changing on `sclk` falling edges) → MOSI equals 0x7F00000000; `rsp_rdata`=0x12345678 at `rsp_valid`.
- `cmd_valid` held high with two queued commands, CS_GAP=4 → `cs` high for ≥4 cycles between frames; `cmd_ready` low throughout each frame; second frame data is correct.
- Assert `rst` at bit 20 of a frame → `cs`=1 and `sclk`=0 in the same cycle; no `rsp_valid`; a following write of 0x00000001 completes with correct MOSI.
- Change `cmd_addr`/`cmd_wdata` one cycle after accept, and pulse `cmd_valid` mid-frame → frame carries the originally latched values; no second frame starts.
- Drive `spi_sint` 0→1 asynchronously, held for 5 cycles → `sint_level` rises within 3 cycles; exactly one `sint_rise` pulse; no pulse when `spi_sint` falls.
